decodificador_morse: RTL

Serial Morse receiver for decimal digits, the counterpart of the `codificador` encoder. It samples a single key line, times each key-down interval to classify it as a dot or a dash, and shifts the symbols into a 5-symbol register. When the end of a character is detected it maps the register to a 4-bit digit 0–9 on `a,b,c,d`. It sits at the receiving end of the Morse link and presents the same `a,b,c,d` / `m1..m5` / `ready` view that the encoder consumes and produces.

---
 rtl/morse_pkg.sv | 51 +++++
 rtl/sincronizador.sv | 22 ++
 rtl/decodificador_morse.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/morse_pkg.sv
// Shared Morse definitions: FSM states, symbol values, digit codes and
// the code-to-digit decode used by both encoder and decoder.
package morse_pkg;

    typedef enum logic [1:0] {
        OCIOSO      = 2'd0,
        PRESSIONADO = 2'd1,
        ESPACO      = 2'd2
    } estado_t;

    localparam logic PONTO = 1'b0;
    localparam logic TRACO = 1'b1;

    // m1 is the MSB of each code, 1 = dash
    localparam logic [4:0] COD_0 = 5'b11111;
    localparam logic [4:0] COD_1 = 5'b01111;
    localparam logic [4:0] COD_2 = 5'b00111;
    localparam logic [4:0] COD_3 = 5'b00011;
    localparam logic [4:0] COD_4 = 5'b00001;
    localparam logic [4:0] COD_5 = 5'b00000;
    localparam logic [4:0] COD_6 = 5'b10000;
    localparam logic [4:0] COD_7 = 5'b11000;
    localparam logic [4:0] COD_8 = 5'b11100;
    localparam logic [4:0] COD_9 = 5'b11110;

    typedef struct packed {
        logic       valido;
        logic [3:0] digito;
    } decod_t;

    function automatic decod_t decodifica(input logic [4:0] cod);
        decod_t r;
        r.valido = 1'b1;
        r.digito = 4'd0;
        unique case (cod)
            COD_0:   r.digito = 4'd0;
            COD_1:   r.digito = 4'd1;
            COD_2:   r.digito = 4'd2;
            COD_3:   r.digito = 4'd3;
            COD_4:   r.digito = 4'd4;
            COD_5:   r.digito = 4'd5;
            COD_6:   r.digito = 4'd6;
            COD_7:   r.digito = 4'd7;
            COD_8:   r.digito = 4'd8;
            COD_9:   r.digito = 4'd9;
            default: r.valido = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sincronizador.sv
// Two-flop synchronizer for the asynchronous key line.
// Used only when MORSE_SYNC_EN is defined.
module sincronizador (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b0;
            dout <= 1'b0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/decodificador_morse.sv
// Serial Morse digit receiver: times key presses into dots/dashes and
// decodes 5-symbol characters. Define MORSE_SYNC_EN to synchronize key.
module decodificador_morse
    import morse_pkg::*;
#(
    parameter int DOT_MAX  = 4,
    parameter int CHAR_GAP = 10,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic m1,
    output logic m2,
    output logic m3,
    output logic m4,
    output logic m5,
    output logic ready,
    output logic erro
);

    localparam logic [CNT_W-1:0] SAT     = '1;
    localparam logic [CNT_W-1:0] UM      = CNT_W'(1);
    localparam logic [CNT_W-1:0] DOT_LIM = CNT_W'(DOT_MAX);
    localparam logic [CNT_W-1:0] GAP_LIM = CNT_W'(CHAR_GAP);

    logic ks;

`ifdef MORSE_SYNC_EN
    sincronizador u_sinc (
        .clk   (clk),
        .reset (reset),
        .din   (key),
        .dout  (ks)
    );
`else
    assign ks = key;
`endif

    estado_t          estado;
    estado_t          prox;
    logic [CNT_W-1:0] cnt_press;
    logic [CNT_W-1:0] cnt_gap;
    logic [2:0]       n_sim;
    logic             ovf;
    logic [4:0]       reg_sim;
    logic [3:0]       digito;
    logic [4:0]       cod;

    logic inicia;
    logic reinicia;
    logic soma_press;
    logic classifica;
    logic soma_gap;
    logic decide;
    logic sim;
    logic valido;
    decod_t dec;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) estado <= OCIOSO;
        else        estado <= prox;
    end

    always_comb begin
        prox = estado;
        unique case (estado)
            OCIOSO:      if (ks) prox = PRESSIONADO;
            PRESSIONADO: if (!ks) prox = ESPACO;
            ESPACO: begin
                if (cnt_gap == GAP_LIM) prox = OCIOSO;
                else if (ks)            prox = PRESSIONADO;
            end
            default:     prox = OCIOSO;
        endcase
    end

    // A full gap decodes even if the key comes back on that same sample
    always_comb begin
        inicia     = 1'b0;
        reinicia   = 1'b0;
        soma_press = 1'b0;
        classifica = 1'b0;
        soma_gap   = 1'b0;
        decide     = 1'b0;
        unique case (estado)
            OCIOSO: inicia = ks;
            PRESSIONADO: begin
                soma_press = ks;
                classifica = !ks;
            end
            ESPACO: begin
                decide   = (cnt_gap == GAP_LIM);
                reinicia = !decide && ks;
                soma_gap = !decide && !ks;
            end
            default: ;
        endcase
    end

    assign sim    = (cnt_press > DOT_LIM) ? TRACO : PONTO;
    assign dec    = decodifica(reg_sim);
    assign valido = dec.valido && (n_sim == 3'd5) && !ovf;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_press <= '0;
            cnt_gap   <= '0;
            n_sim     <= 3'd0;
            ovf       <= 1'b0;
            reg_sim   <= 5'b0;
        end else begin
            if (inicia || reinicia) cnt_press <= UM;
            if (inicia) begin
                n_sim <= 3'd0;
                ovf   <= 1'b0;
            end
            if (soma_press && cnt_press != SAT)
                cnt_press <= cnt_press + UM;
            if (classifica) begin
                cnt_gap <= UM;
                if (n_sim == 3'd5) begin
                    ovf <= 1'b1;
                end else begin
                    reg_sim <= {reg_sim[3:0], sim};
                    n_sim   <= n_sim + 3'd1;
                end
            end
            if (soma_gap) cnt_gap <= cnt_gap + UM;
            if (decide) begin
                cnt_press <= '0;
                cnt_gap   <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digito <= 4'd0;
            cod    <= 5'b0;
            ready  <= 1'b0;
            erro   <= 1'b0;
        end else begin
            ready <= 1'b0;
            erro  <= 1'b0;
            if (decide) begin
                if (valido) begin
                    ready  <= 1'b1;
                    digito <= dec.digito;
                    cod    <= reg_sim;
                end else begin
                    erro <= 1'b1;
                end
            end
        end
    end

    assign {a, b, c, d}         = digito;
    assign {m1, m2, m3, m4, m5} = cod;

endmodule
